// File: rtl/lib_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lib_uart (package)
// Description : Shared UART types: FSM state encoding and the packed
//               interfaces exchanged with the execute stage and the
//               special-register file.
// Revision    : 1.0 - initial release
// ============================================================================
package lib_uart;

    // Common state encoding for the TX and RX bit-level FSMs.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } UART_STATE;

    // Transmit request as produced by the execute stage.
    typedef struct packed {
        logic       w_req;
        logic [7:0] w_data;
    } UART_TX_IF;

    // Receive status as consumed by the special-register file.
    typedef struct packed {
        logic       irr;
        logic [7:0] r_data;
    } UART_RX_IF;

endpackage : lib_uart
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 receiver: 2-flop synchroniser, bit-timing FSM and
//               LSB-first shift register. Emits a one-cycle valid pulse
//               with the byte when a frame ends with a good stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);

    localparam int              c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    logic               r_sync1;
    logic               r_rx_s;
    UART_STATE          r_state;
    UART_STATE          w_state_n;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_n;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_n;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_n;
    logic               w_valid;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
        end
    end

    // FSM state, bit-timing counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
        end
    end

    // Next-state logic: start bit checked at its centre, data and stop bits
    // sampled one bit period apart so every sample lands near a bit centre.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_idx_n = '0;
                if (!r_rx_s) begin
                    w_state_n = START;
                    w_cnt_n   = '0;
                end
            end
            START: begin
                if (r_cnt == c_half) begin
                    w_cnt_n   = '0;
                    w_state_n = r_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == c_last) begin
                    w_cnt_n   = '0;
                    w_shift_n = {r_rx_s, r_shift[7:1]};
                    w_idx_n   = r_idx + 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_n = STOP;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == c_last) begin
                    // Leave mid-stop-bit so a following start edge is caught.
                    w_cnt_n   = '0;
                    w_valid   = r_rx_s;
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign o_valid = w_valid;
    assign o_data  = r_shift;

endmodule : uart_rx_core
`default_nettype wire

// File: rtl/uart_io.sv
`default_nettype none
// ============================================================================
// Module      : uart_io
// Description : Byte-serial UART peripheral for the CPU core. 8N1 transmit
//               FSM, receive path with interrupt flag cleared by ack.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_io
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_req,
    input  logic [7:0] w_data,
    input  logic       ack,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       w_busy,
    output logic       irr,
    output logic [7:0] r_data
);

    localparam int              c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    UART_TX_IF          w_tx_if;
    UART_RX_IF          r_rx_if;

    UART_STATE          r_tx_state;
    UART_STATE          w_tx_state_n;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [c_cnt_w-1:0] w_tx_cnt_n;
    logic [2:0]         r_tx_idx;
    logic [2:0]         w_tx_idx_n;
    logic [7:0]         r_tx_shift;
    logic [7:0]         w_tx_shift_n;
    logic               w_tx_line_n;
    logic               r_uart_tx;
    logic               r_busy;

    logic               w_rx_valid;
    logic [7:0]         w_rx_byte;

    assign w_tx_if = '{w_req: w_req, w_data: w_data};

    // TX state, counters and registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_uart_tx  <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_idx   <= w_tx_idx_n;
            r_tx_shift <= w_tx_shift_n;
            r_uart_tx  <= w_tx_line_n;
            r_busy     <= (w_tx_state_n != IDLE);
        end
    end

    // TX next-state: requests are accepted only in IDLE; each bit lasts one
    // full bit period. The line level is decoded from the next state so the
    // output flop changes on the same edge as the state.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_idx_n   = r_tx_idx;
        w_tx_shift_n = r_tx_shift;
        case (r_tx_state)
            IDLE: begin
                if (w_tx_if.w_req) begin
                    w_tx_state_n = START;
                    w_tx_cnt_n   = '0;
                    w_tx_idx_n   = '0;
                    w_tx_shift_n = w_tx_if.w_data;
                end
            end
            START: begin
                if (r_tx_cnt == c_last) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_tx_cnt == c_last) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    w_tx_idx_n   = r_tx_idx + 1'b1;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_n = STOP;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_tx_cnt == c_last) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = IDLE;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_state_n = IDLE;
                w_tx_cnt_n   = '0;
            end
        endcase

        case (w_tx_state_n)
            START:   w_tx_line_n = 1'b0;
            DATA:    w_tx_line_n = w_tx_shift_n[0];
            default: w_tx_line_n = 1'b1;
        endcase
    end

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk     (clk),
        .reset   (reset),
        .i_rx    (uart_rx),
        .o_valid (w_rx_valid),
        .o_data  (w_rx_byte)
    );

    // Receive flag and data: a completed frame takes priority over ack, and
    // an unread byte is simply overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_if <= '0;
        end else if (w_rx_valid) begin
            r_rx_if.irr    <= 1'b1;
            r_rx_if.r_data <= w_rx_byte;
        end else if (ack) begin
            r_rx_if.irr <= 1'b0;
        end
    end

    assign uart_tx = r_uart_tx;
    assign w_busy  = r_busy;
    assign irr     = r_rx_if.irr;
    assign r_data  = r_rx_if.r_data;

endmodule : uart_io
`default_nettype wire

// File: tb/tb_uart_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_io
// Description : Self-checking bench for uart_io with CLKS_PER_BIT=4. TX line
//               levels and RX bytes are queued when stimulus is driven and
//               popped when the DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_io;

    localparam int c_cpb = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       w_req;
    logic [7:0] w_data;
    logic       ack;
    logic       uart_rx;
    logic       uart_tx;
    logic       w_busy;
    logic       irr;
    logic [7:0] r_data;

    int errors = 0;
    int checks = 0;

    logic       exp_bits[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] last_rx;

    uart_io #(
        .CLKS_PER_BIT (c_cpb)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .w_req   (w_req),
        .w_data  (w_data),
        .ack     (ack),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .w_busy  (w_busy),
        .irr     (irr),
        .r_data  (r_data)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Global time limit so the run always terminates.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Serialise one 8N1 frame onto uart_rx; good frames are queued.
    task automatic send_frame(input logic [7:0] d, input logic stopb);
        logic [9:0] f;
        f = {stopb, d, 1'b0};
        if (stopb) exp_bytes.push_back(d);
        for (int s = 0; s < 10; s++) begin
            uart_rx = f[s];
            repeat (c_cpb) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // Wait (bounded) for a queued byte to appear, then compare.
    task automatic expect_rx(input string name);
        logic [7:0] e;
        if (exp_bytes.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_bytes.pop_front();
        for (int i = 0; i < 8 && !(irr === 1'b1 && r_data === e); i++) @(negedge clk);
        checks++;
        if (irr !== 1'b1) begin
            errors++;
            $display("FAIL %s_irr: got %b want 1", name, irr);
        end
        checks++;
        if (r_data !== e) begin
            errors++;
            $display("FAIL %s_data: got %h want %h", name, r_data, e);
        end
        last_rx = e;
    endtask

    // Send one byte and check line levels and busy for all 40 cycles.
    task automatic run_tx(input logic [7:0] d, input bit collide, input string name);
        logic b;
        exp_bits.delete();
        repeat (c_cpb) exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (c_cpb) exp_bits.push_back(d[i]);
        repeat (c_cpb) exp_bits.push_back(1'b1);
        w_data = d;
        w_req  = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10 * c_cpb; k++) begin
            if (collide && k == 10) begin
                w_data = 8'h3C;
                w_req  = 1'b1;
            end else begin
                w_req = 1'b0;
            end
            b = exp_bits.pop_front();
            checks++;
            if (uart_tx !== b) begin
                errors++;
                $display("FAIL %s_line[%0d]: got %b want %b", name, k, uart_tx, b);
            end
            checks++;
            if (w_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy[%0d]: got %b want 1", name, k, w_busy);
            end
            @(negedge clk);
        end
        w_req = 1'b0;
        checks++;
        if (w_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_drop: got %b want 0", name, w_busy);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        w_req   = 1'b0;
        w_data  = 8'h00;
        ack     = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        checks++;
        if (w_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", w_busy); end
        checks++;
        if (irr !== 1'b0) begin errors++; $display("FAIL reset_irr: got %b want 0", irr); end
        checks++;
        if (r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", r_data); end
        last_rx = 8'h00;
    endtask

    task automatic test_tx();
        run_tx(8'hA5, 1'b0, "tx_a5");
    endtask

    task automatic test_tx_collision();
        run_tx(8'hA5, 1'b1, "tx_coll");
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (uart_tx !== 1'b1 || w_busy !== 1'b0) begin
                errors++;
                $display("FAIL tx_coll_idle[%0d]: got tx=%b busy=%b want tx=1 busy=0", k, uart_tx, w_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rx();
        send_frame(8'h5A, 1'b1);
        expect_rx("rx_5a");
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (irr !== 1'b0) begin errors++; $display("FAIL rx_ack_irr: got %b want 0", irr); end
        checks++;
        if (r_data !== last_rx) begin errors++; $display("FAIL rx_ack_data: got %h want %h", r_data, last_rx); end
        // ack with nothing pending leaves everything alone
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (irr !== 1'b0 || r_data !== last_rx) begin
            errors++;
            $display("FAIL rx_ack_idle: got irr=%b data=%h want irr=0 data=%h", irr, r_data, last_rx);
        end
    endtask

    task automatic test_rx_errors();
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (irr !== 1'b0) begin errors++; $display("FAIL rx_false_start: got irr=%b want 0", irr); end
        send_frame(8'hFF, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (irr !== 1'b0) begin errors++; $display("FAIL rx_frame_err_irr: got %b want 0", irr); end
        checks++;
        if (r_data !== last_rx) begin errors++; $display("FAIL rx_frame_err_data: got %h want %h", r_data, last_rx); end
    endtask

    task automatic test_back_to_back();
        // Two frames with no idle gap; the second overruns the unread first.
        send_frame(8'h3C, 1'b1);
        send_frame(8'h42, 1'b1);
        expect_rx("b2b_first");
        expect_rx("b2b_overrun");
        repeat (4) @(negedge clk);
    endtask

    task automatic test_race();
        logic [7:0] e;
        // irr is 1 here; ack is high on exactly the edge that completes 0x81.
        send_frame(8'h81, 1'b1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        e = exp_bytes.pop_front();
        checks++;
        if (irr !== 1'b1) begin errors++; $display("FAIL race_irr: got %b want 1", irr); end
        checks++;
        if (r_data !== e) begin errors++; $display("FAIL race_data: got %h want %h", r_data, e); end
        last_rx = e;
        @(negedge clk);
        checks++;
        if (irr !== 1'b1) begin errors++; $display("FAIL race_hold: got %b want 1", irr); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (irr !== 1'b0) begin errors++; $display("FAIL race_clear: got %b want 0", irr); end
    endtask

    task automatic test_reset_abort();
        w_data = 8'h99;
        w_req  = 1'b1;
        @(negedge clk);
        w_req = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (uart_tx !== 1'b1 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_tx: got tx=%b busy=%b want tx=1 busy=0", uart_tx, w_busy);
        end
        checks++;
        if (irr !== 1'b0 || r_data !== 8'h00) begin
            errors++;
            $display("FAIL abort_rx: got irr=%b data=%h want irr=0 data=00", irr, r_data);
        end
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            checks++;
            if (uart_tx !== 1'b1 || w_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle[%0d]: got tx=%b busy=%b want tx=1 busy=0", k, uart_tx, w_busy);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tx();
        test_tx_collision();
        test_rx();
        test_rx_errors();
        test_back_to_back();
        test_race();
        test_reset_abort();
        checks++;
        if (exp_bytes.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_bytes.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_io
`default_nettype wire

// File: doc/uart_io.md
Name: uart_io

Overview:
- Byte-serial I/O peripheral between the CPU core and the board UART pins.
- Consumes the execute stage's w_req/w_data/ack outputs.
- Produces the w_busy/irr/r_data special-register inputs sampled by decode.
- TX is 8N1 serialisation. RX is 8N1 deserialisation with a receive-interrupt flag, cleared by ack.

Parameters:
- CLKS_PER_BIT, 234: clock cycles per UART bit (27 MHz / 115200). Must be ≥4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- w_req  in  1  execute requests transmission of w_data (single-cycle pulse)
- w_data  in  8  byte to transmit
- ack  in  1  execute acknowledges received byte; clears irr
- uart_rx  in  1  asynchronous serial input, idle high
- uart_tx  out  1  serial output, idle high
- w_busy  out  1  transmitter busy
- irr  out  1  receive interrupt request: unread byte in r_data
- r_data  out  8  last received byte

Behaviour:
- Reset (synchronous, active-high, one clock):
  - Outputs: uart_tx=1, w_busy=0, irr=0, r_data=8'h00.
  - Both FSMs return to IDLE, counters clear, RX synchroniser flops load 1.
  - Reset mid-frame aborts the frame immediately; no partial byte is ever reported.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with w_req=1: latch w_data into the shift register and go to START. On the next edge w_busy=1 and uart_tx=0.
  - START, each DATA bit and STOP are each held exactly CLKS_PER_BIT cycles. DATA is sent LSB first over 8 bits, tracked by a 3-bit index. STOP drives 1.
  - At the end of STOP go to IDLE; w_busy=0 on that edge. Busy duration is exactly 10*CLKS_PER_BIT cycles.
  - w_req while w_busy=1 is ignored (byte dropped). Software polls w_busy.
  - w_req on the same cycle that STOP completes is ignored; acceptance happens only in IDLE.
- RX path:
  - uart_rx passes through a 2-flop synchroniser; the FSM sees rx_s.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: rx_s=0 goes to START and clears the counter.
  - START: when the counter reaches CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - 0: go to DATA and reset the counter.
    - 1: false start; go back to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles (bit centre) and shift into bit 7 of the shift register (LSB-first arrival). After 8 samples go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - 1: valid frame; on that edge r_data<=shift register and irr<=1.
    - 0: framing error; discard the byte and leave irr and r_data unchanged.
    - Either way, go to IDLE at that edge (mid-stop-bit), so back-to-back frames are received.
- irr/ack:
  - irr is set by a valid frame and cleared by ack=1 on the next edge.
  - Valid frame and ack on the same cycle: set wins, so irr stays 1 and r_data takes the new byte.
  - Overrun (valid frame while irr=1): r_data is overwritten and irr stays 1. No overrun flag.
  - ack with irr=0: no effect.
  - r_data changes only on a valid frame or reset.
- Counters: width $clog2(CLKS_PER_BIT). They wrap to 0 at CLKS_PER_BIT-1 and never exceed it.
- TX and RX are fully independent; simultaneous activity is allowed.

Decomposition:
- Add to shared package lib_uart:
  - enum UART_STATE {IDLE, START, DATA, STOP} (2-bit), used by both FSMs.
  - packed struct UART_TX_IF {w_req, w_data}, matching the EXECUTE fields.
  - packed struct UART_RX_IF {irr, r_data}, matching the SPECIAL_REG fields.
- One sub-module: uart_rx_core, containing the synchroniser, RX FSM and shift register. It outputs a one-cycle valid pulse plus the byte.
- uart_io keeps the TX FSM and the irr/ack flag logic inline.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
- Reset: hold reset 3 cycles with uart_rx=1 -> uart_tx=1, w_busy=0, irr=0, r_data=8'h00.
- TX 8'hA5: 1-cycle w_req -> next edge w_busy=1, uart_tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), stop 1 for 4; w_busy=0 exactly 40 cycles after it rose.
- TX collision: w_req with 8'h3C at cycle 10 of the 8'hA5 frame -> line carries only 8'hA5; no second frame; w_busy drops at cycle 40.
- RX 8'h5A: drive a valid frame -> irr=1, r_data=8'h5A. Then pulse ack 1 cycle -> irr=0 next edge, r_data stays 8'h5A.
- RX errors:
  - uart_rx low for 1 cycle -> false start, irr stays 0.
  - Frame 8'hFF with stop=0 -> irr stays 0, r_data unchanged.
- Set/clear race and reset abort:
  - With irr=1, hold ack=1 across completion of frame 8'h81 -> irr=1, r_data=8'h81.
  - Assert reset mid-TX -> next edge uart_tx=1, w_busy=0.
